loop_perf_recorder: RTL and testbench

- Synthesizable, cycle-accurate recorder for one pipelined HLS loop instance (e.g. a CYCLE or EXTRACT loop).
- Watches the loop's FSM state, block, enable and start/done handshake signals.
- Per invocation, counts total cycles, completed iterations and start-stage stall cycles, then pushes one record into an internal FIFO.
- The CSV dump side drains the FIFO over a valid/ready port. The block sits between the loop RTL and that dump side.

---
 rtl/loop_perf_recorder.sv | 245 ++++++++++++++++++++++++
 tb/tb_loop_perf_recorder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/loop_perf_recorder.sv
// loop_perf_recorder
//   Cycle-accurate performance recorder for one pipelined HLS loop instance.
//   It watches the loop FSM state, the stage block/enable signals and the
//   start/done handshake. For each invocation it counts total cycles,
//   completed iterations and start-stage stall cycles. When the invocation
//   closes, it pushes one record into a small show-ahead FIFO. The CSV dump
//   side drains that FIFO over a valid/ready port.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   cur_state             loop ap_CS_fsm (one-hot)
//   iter_start_state      state code of the first pipeline stage
//   iter_end_state        state code of the last pipeline stage
//   iter_start_block      subdone block of the start stage
//   iter_end_block        subdone block of the end stage
//   iter_start_enable     enable of the first iteration register
//   iter_end_enable       enable of the last iteration register
//   loop_start            loop ap_start
//   loop_done             loop ap_done_int
//   loop_continue         qualifies loop_done
//   finish                simulation finish request (moves to HALT)
//   rec_valid/rec_ready   record FIFO head handshake
//   rec_cycles/iters/stalls/incomplete  head record fields (0 when empty)
//   busy                  high while an invocation is being recorded
//   dropped               saturating count of records lost to a full FIFO
module loop_perf_recorder #(
    parameter int STATE_W    = 8,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               loop_start,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               finish,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [CNT_W-1:0]   rec_cycles,
    output logic [CNT_W-1:0]   rec_iters,
    output logic [CNT_W-1:0]   rec_stalls,
    output logic               rec_incomplete,
    output logic               busy,
    output logic [7:0]         dropped
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
        if (en && (v != 8'hFF)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] itr_q, itr_d;
    logic [CNT_W-1:0] stl_q, stl_d;

    logic             iter_end_ev;
    logic             stall_ev;
    logic             done_ev;
    logic [CNT_W-1:0] cyc_inc, itr_inc, stl_inc;

    logic             push;
    logic             push_incomplete;

    // Event decode: combinational on this cycle's loop signals
    always_comb begin
        iter_end_ev = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
        stall_ev    = (cur_state == iter_start_state) && iter_start_enable && iter_start_block;
        done_ev     = loop_done && loop_continue;
        cyc_inc     = sat_inc(cyc_q, 1'b1);
        itr_inc     = sat_inc(itr_q, iter_end_ev);
        stl_inc     = sat_inc(stl_q, stall_ev);
    end

    // Control FSM and counters
    always_comb begin
        state_d         = state_q;
        cyc_d           = cyc_q;
        itr_d           = itr_q;
        stl_d           = stl_q;
        push            = 1'b0;
        push_incomplete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (finish) begin
                    state_d = ST_HALT;
                end else if (loop_start) begin
                    // The start cycle is cycle 1 and its events already count.
                    state_d = ST_RUN;
                    cyc_d   = CNT_W'(1);
                    itr_d   = CNT_W'(iter_end_ev);
                    stl_d   = CNT_W'(stall_ev);
                end
            end
            ST_RUN: begin
                cyc_d = cyc_inc;
                itr_d = itr_inc;
                stl_d = stl_inc;
                if (done_ev) begin
                    push = 1'b1;
                    if (finish) begin
                        state_d = ST_HALT;
                    end else if (loop_start) begin
                        // Shared done/start cycle: it closes the old record
                        // and is cycle 1 of the next invocation.
                        cyc_d = CNT_W'(1);
                        itr_d = '0;
                        stl_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (finish) begin
                    push            = 1'b1;
                    push_incomplete = 1'b1;
                    state_d         = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            itr_q   <= '0;
            stl_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            itr_q   <= itr_d;
            stl_q   <= stl_d;
        end
    end

    // Record FIFO (show-ahead)
    logic [CNT_W-1:0] mem_cyc_q [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_itr_q [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_stl_q [FIFO_DEPTH];
    logic             mem_inc_q [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [7:0]       drop_q, drop_d;

    logic             empty, full, pop, accept, drop_ev;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == DEPTH_C);
        pop     = !empty && rec_ready;
        // A full FIFO still takes a push when the head leaves the same cycle.
        accept  = push && (!full || pop);
        drop_ev = push && full && !pop;

        rd_d = rd_q;
        wr_d = wr_q;
        cnt_d = cnt_q;
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (accept) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (accept && !pop) begin
            cnt_d = cnt_q + (PTR_W + 1)'(1);
        end else if (pop && !accept) begin
            cnt_d = cnt_q - (PTR_W + 1)'(1);
        end
        drop_d = sat_inc8(drop_q, drop_ev);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Storage carries no reset; entries are only observed through cnt_q.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_cyc_q[wr_q] <= cyc_inc;
            mem_itr_q[wr_q] <= itr_inc;
            mem_stl_q[wr_q] <= stl_inc;
            mem_inc_q[wr_q] <= push_incomplete;
        end
    end

    always_comb begin
        rec_valid      = !empty;
        rec_cycles     = '0;
        rec_iters      = '0;
        rec_stalls     = '0;
        rec_incomplete = 1'b0;
        if (!empty) begin
            rec_cycles     = mem_cyc_q[rd_q];
            rec_iters      = mem_itr_q[rd_q];
            rec_stalls     = mem_stl_q[rd_q];
            rec_incomplete = mem_inc_q[rd_q];
        end
        busy    = (state_q == ST_RUN);
        dropped = drop_q;
    end

endmodule

// File: tb/tb_loop_perf_recorder.sv
module tb_loop_perf_recorder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  cur_state, iter_start_state, iter_end_state;
    logic        iter_start_block, iter_end_block;
    logic        iter_start_enable, iter_end_enable;
    logic        loop_start, loop_done, loop_continue, finish, rec_ready;

    logic        rec_valid, rec_incomplete, busy;
    logic [31:0] rec_cycles, rec_iters, rec_stalls;
    logic [7:0]  dropped;

    logic        s_rec_valid, s_rec_incomplete, s_busy;
    logic [3:0]  s_rec_cycles, s_rec_iters, s_rec_stalls;
    logic [7:0]  s_dropped;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    loop_perf_recorder #(.STATE_W(8), .CNT_W(32), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .loop_start(loop_start), .loop_done(loop_done), .loop_continue(loop_continue),
        .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_cycles(rec_cycles), .rec_iters(rec_iters), .rec_stalls(rec_stalls),
        .rec_incomplete(rec_incomplete), .busy(busy), .dropped(dropped)
    );

    loop_perf_recorder #(.STATE_W(8), .CNT_W(4), .FIFO_DEPTH(4)) dut_small (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .loop_start(loop_start), .loop_done(loop_done), .loop_continue(loop_continue),
        .finish(finish), .rec_valid(s_rec_valid), .rec_ready(rec_ready),
        .rec_cycles(s_rec_cycles), .rec_iters(s_rec_iters), .rec_stalls(s_rec_stalls),
        .rec_incomplete(s_rec_incomplete), .busy(s_busy), .dropped(s_dropped)
    );

    // ctl = {sblk, een, ls, ld, lc, fin, rdy}; flg = {vld, inc, busy}
    typedef struct packed {
        logic [7:0]  cs, ss, es;
        logic [6:0]  ctl;
        logic [2:0]  flg;
        logic [31:0] cyc, itr, stl;
        logic [7:0]  drop;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [7:0] cs, input logic [7:0] ss,
                                input logic [7:0] es, input logic [6:0] ctl,
                                input logic [2:0] flg, input int cyc,
                                input int itr, input int stl, input int drop);
        vec_t v;
        v.cs = cs; v.ss = ss; v.es = es; v.ctl = ctl; v.flg = flg;
        v.cyc = cyc; v.itr = itr; v.stl = stl; v.drop = drop[7:0];
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ctl(input logic [6:0] ctl);
        {iter_start_block, iter_end_enable, loop_start, loop_done,
         loop_continue, finish, rec_ready} = ctl;
    endtask

    initial begin
        vec_t v;
        logic [2:0]  got_flg;
        // Single invocation, 1-state loop: end enable rises after 2 fill cycles.
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0010100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0000100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0101000, 3'b001, 0, 0, 0, 0)); // done w/o continue
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0101100, 3'b100, 10, 8, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0000100, 3'b100, 10, 8, 0, 0)); // held
        vq.push_back(mk(8'h01, 8'h01, 8'h01, 7'b0000101, 3'b000, 0, 0, 0, 0));
        // 4-stage baseline
        vq.push_back(mk(8'h01, 8'h01, 8'h08, 7'b0110100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h02, 8'h01, 8'h08, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h04, 8'h01, 8'h08, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h08, 8'h01, 8'h08, 7'b0101100, 3'b100, 4, 1, 0, 0));
        vq.push_back(mk(8'h08, 8'h01, 8'h08, 7'b0000101, 3'b000, 0, 0, 0, 0));
        // 4-stage with 3 blocked start-stage cycles
        vq.push_back(mk(8'h01, 8'h01, 8'h08, 7'b1110100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h08, 7'b1100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h08, 7'b1100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h01, 8'h01, 8'h08, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h02, 8'h01, 8'h08, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h04, 8'h01, 8'h08, 7'b0100100, 3'b001, 0, 0, 0, 0));
        vq.push_back(mk(8'h08, 8'h01, 8'h08, 7'b0101100, 3'b100, 7, 1, 3, 0));
        vq.push_back(mk(8'h08, 8'h01, 8'h08, 7'b0000101, 3'b000, 0, 0, 0, 0));

        reset = 1'b1;
        cur_state = 8'h01; iter_start_state = 8'h01; iter_end_state = 8'h01;
        iter_end_block = 1'b0; iter_start_enable = 1'b1;
        set_ctl(7'b0000100);
        step(); step();
        chk("reset_valid", 32'(rec_valid), 0);
        chk("reset_cycles", rec_cycles, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dropped", 32'(dropped), 0);
        chk("reset_incomplete", 32'(rec_incomplete), 0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            cur_state = v.cs; iter_start_state = v.ss; iter_end_state = v.es;
            set_ctl(v.ctl);
            step();
            got_flg = {rec_valid, rec_incomplete, busy};
            n_vec++;
            if (got_flg !== v.flg || rec_cycles !== v.cyc || rec_iters !== v.itr ||
                rec_stalls !== v.stl || dropped !== v.drop) begin
                n_bad++;
                $display("FAIL vec%0d: got vld/inc/busy=%b cyc=%0d itr=%0d stl=%0d drop=%0d, expected %b cyc=%0d itr=%0d stl=%0d drop=%0d",
                         i, got_flg, rec_cycles, rec_iters, rec_stalls, dropped,
                         v.flg, v.cyc, v.itr, v.stl, v.drop);
            end
        end

        // Back-to-back: five invocations of 2..6 cycles, consumer stalled.
        cur_state = 8'h01; iter_start_state = 8'h01; iter_end_state = 8'h01;
        set_ctl(7'b0010100);
        step();
        for (int i = 1; i <= 5; i++) begin
            for (int k = 1; k <= i; k++) begin
                loop_done  = (k == i);
                loop_start = (k == i) && (i < 5);
                step();
            end
        end
        set_ctl(7'b0000100);
        chk("b2b_valid", 32'(rec_valid), 1);
        chk("b2b_dropped", 32'(dropped), 1);
        chk("b2b_busy", 32'(busy), 0);
        rec_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            chk("b2b_order", rec_cycles, 32'(j));
            step();
        end
        chk("b2b_drained", 32'(rec_valid), 0);
        rec_ready = 1'b0;

        // finish in RUN at cycle 7
        loop_start = 1'b1;
        step();
        loop_start = 1'b0;
        repeat (5) step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        chk("fin_cycles", rec_cycles, 7);
        chk("fin_incomplete", 32'(rec_incomplete), 1);
        chk("fin_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            loop_start = 1'b1; step();
            loop_start = 1'b0; step();
        end
        chk("halt_head_stable", rec_cycles, 7);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        loop_start = 1'b1; step(); step();
        loop_start = 1'b0; loop_done = 1'b1; step();
        loop_done = 1'b0; step();
        chk("halt_no_record", 32'(rec_valid), 0);
        chk("halt_busy", 32'(busy), 0);

        reset = 1'b1; step();
        reset = 1'b0;

        // Saturation: 20-cycle run, iteration end every cycle.
        set_ctl(7'b0110100);
        step();
        loop_start = 1'b0;
        repeat (18) step();
        loop_done = 1'b1; step();
        loop_done = 1'b0;
        chk("sat_main_cycles", rec_cycles, 20);
        chk("sat_main_iters", rec_iters, 20);
        chk("sat_small_cycles", 32'(s_rec_cycles), 15);
        chk("sat_small_iters", 32'(s_rec_iters), 15);

        // Second record queued, then reset in the middle of a third run.
        loop_start = 1'b1; step();
        loop_start = 1'b0; step();
        loop_done = 1'b1; step();
        loop_done = 1'b0;
        chk("q2_head", rec_cycles, 20);
        loop_start = 1'b1; step();
        loop_start = 1'b0; step();
        chk("pre_reset_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rec_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_dropped", 32'(dropped), 0);
        chk("async_rst_small_valid", 32'(s_rec_valid), 0);
        step();
        reset = 1'b0;
        loop_start = 1'b1; step();
        loop_start = 1'b0; step();
        loop_done = 1'b1; step();
        loop_done = 1'b0;
        chk("fresh_cycles", rec_cycles, 3);
        chk("fresh_iters", rec_iters, 3);
        chk("fresh_stalls", rec_stalls, 0);
        chk("fresh_incomplete", 32'(rec_incomplete), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
